// File: rtl/seg_serial_driver_if.sv
// Request/status bundle for the 7-segment serial chain driver.
// The master issues frames; the slave (driver) reports progress.
interface seg_serial_driver_if #(
  parameter int DIGITS = 8
);
  logic                  start;
  logic                  raw_mode;
  logic [4*DIGITS-1:0]   data;
  logic [8*DIGITS-1:0]   raw;
  logic [DIGITS-1:0]     dp;
  logic                  busy;
  logic                  done;

  modport master (
    output start,
    output raw_mode,
    output data,
    output raw,
    output dp,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  raw_mode,
    input  data,
    input  raw,
    input  dp,
    output busy,
    output done
  );
endinterface

// File: rtl/seg_serial_driver.sv
// Serial shifter for a chain of 7-segment digits (hex or raw bytes),
// with an optional free-running auto-refresh trigger.
module seg_serial_driver #(
  parameter int DIGITS  = 8,
  parameter int CLK_DIV = 2,
  parameter int REFRESH = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_serial_driver_if.slave bus,
  output logic               o_segclk,
  output logic               o_segdt,
  output logic               o_segclr,
  output logic               o_segen
);

  localparam int NB = 8 * DIGITS;
  localparam int BW = $clog2(NB);
  localparam int RW =
    (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam logic [7:0] DIV_M1 =
    8'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST =
    BW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    FIN
  } state_t;

  state_t          r_state;
  logic [NB-1:0]   r_shift;
  logic [7:0]      r_cnt;
  logic [BW-1:0]   r_bit;
  logic            r_busy;
  logic            r_done;
  logic            r_segclk;
  logic            r_segdt;
  logic            r_on;
  logic            w_ref_tick;
  logic            w_go;
  logic [NB-1:0]   w_frame;

  function automatic logic [7:0] hex7(
    input logic [3:0] n
  );
    logic [7:0] s;
    s = 8'hFF;
    unique case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Digit DIGITS-1 lands in the top byte so it leaves first.
  always_comb begin
    w_frame = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.raw_mode)
        w_frame[8*i +: 8] = bus.raw[8*i +: 8];
      else
        w_frame[8*i +: 8] =
          hex7(bus.data[4*i +: 4]) &
          ~{bus.dp[i], 7'b0};
    end
  end

  generate
    if (REFRESH > 0) begin : g_ref
      logic [RW-1:0] r_ref;
      assign w_ref_tick =
        (r_ref == RW'(REFRESH - 1));
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_ref <= '0;
        else if (w_ref_tick)
          r_ref <= '0;
        else
          r_ref <= r_ref + 1'b1;
      end
    end else begin : g_noref
      assign w_ref_tick = 1'b0;
    end
  endgenerate

  assign w_go = (r_state == IDLE) &&
                (bus.start || w_ref_tick);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_segclk <= 1'b0;
      r_segdt  <= 1'b0;
      r_on     <= 1'b0;
    end else begin
      r_on   <= 1'b1;
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_go) begin
            r_state <= LOW;
            r_shift <= w_frame;
            r_segdt <= w_frame[NB-1];
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
          end
        end
        LOW: begin
          if (r_cnt == DIV_M1) begin
            r_state  <= HIGH;
            r_segclk <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        HIGH: begin
          if (r_cnt == DIV_M1) begin
            r_cnt    <= '0;
            r_segclk <= 1'b0;
            if (r_bit == LAST) begin
              r_state <= FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= LOW;
              r_bit   <= r_bit + 1'b1;
              r_shift <= r_shift << 1;
              r_segdt <= r_shift[NB-2];
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign o_segclk = r_segclk;
  assign o_segdt  = r_segdt;
  assign o_segclr = r_on;
  assign o_segen  = r_on;

endmodule

// File: tb/tb_seg_serial_driver.sv
// Scoreboard bench for seg_serial_driver: random and directed frames,
// mid-frame reset, busy/FIN start rejection and auto-refresh timing.
module tb_seg_serial_driver;

  localparam int D  = 8;
  localparam int CD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_n_r = 1'b0;
  always #5 clk = ~clk;

  seg_serial_driver_if #(.DIGITS(D)) bus0();
  seg_serial_driver_if #(.DIGITS(D)) bus1();
  seg_serial_driver_if #(.DIGITS(D)) bus2();

  logic sc0, sd0, cl0, en0;
  logic sc1, sd1, cl1, en1;
  logic sc2, sd2, cl2, en2;

  seg_serial_driver #(
    .DIGITS(D), .CLK_DIV(CD), .REFRESH(0)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .o_segclk(sc0), .o_segdt(sd0),
    .o_segclr(cl0), .o_segen(en0)
  );

  seg_serial_driver #(
    .DIGITS(D), .CLK_DIV(CD), .REFRESH(300)
  ) u1 (
    .clk(clk), .rst_n(rst_n_r), .bus(bus1),
    .o_segclk(sc1), .o_segdt(sd1),
    .o_segclr(cl1), .o_segen(en1)
  );

  seg_serial_driver #(
    .DIGITS(D), .CLK_DIV(CD), .REFRESH(200)
  ) u2 (
    .clk(clk), .rst_n(rst_n_r), .bus(bus2),
    .o_segclk(sc2), .o_segdt(sd2),
    .o_segclr(cl2), .o_segen(en2)
  );

  int n_chk = 0;
  int n_err = 0;
  int exp_done = 0;
  int got_done = 0;
  int cyc_r = 0;
  logic [7:0] exp_q[$];
  int st1[$];
  int st2[$];

  logic [7:0] lut [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  task automatic chk(
    input string name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Expected bytes in wire order; returns the first one.
  function automatic logic [7:0] model(
    input bit rm,
    input logic [31:0] d,
    input logic [63:0] r,
    input logic [7:0] p
  );
    logic [7:0] b;
    logic [7:0] first;
    first = 8'h00;
    for (int i = D - 1; i >= 0; i--) begin
      if (rm) begin
        b = r[8*i +: 8];
      end else begin
        b = lut[d[4*i +: 4]];
        if (p[i]) b[7] = 1'b0;
      end
      if (i == D - 1) first = b;
      exp_q.push_back(b);
    end
    return first;
  endfunction

  always @(posedge clk) begin
    if (rst_n_r) cyc_r = cyc_r + 1;
    else cyc_r = 0;
  end

  logic pb1 = 1'b0;
  logic pb2 = 1'b0;
  always @(negedge clk) begin
    if (rst_n_r) begin
      if (bus1.busy && !pb1) st1.push_back(cyc_r);
      if (bus2.busy && !pb2) st2.push_back(cyc_r);
      pb1 = bus1.busy;
      pb2 = bus2.busy;
    end
  end

  logic       p_sc, p_busy, p_done, p_dt, dt_rise;
  logic [7:0] acc;
  int         low_n, high_n, busy_n, stab, nbits;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_sc = 0; p_busy = 0; p_done = 0; p_dt = 0;
      low_n = 0; high_n = 0; busy_n = 0;
      stab = 0; nbits = 0; acc = 0; dt_rise = 0;
    end else begin
      if (sd0 !== p_dt) stab = 1;
      else stab++;
      if (!sc0 && bus0.busy) low_n++;
      if (sc0 && !p_sc) begin
        chk("low_phase", low_n, CD);
        chk("setup", stab > CD, 1);
        low_n = 0;
        high_n = 1;
        dt_rise = sd0;
        acc = {acc[6:0], sd0};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL byte: got %0h expected none",
                     acc);
          end else begin
            chk("byte", acc, exp_q.pop_front());
          end
        end
      end else if (sc0) begin
        high_n++;
        chk("hold", sd0, dt_rise);
      end
      if (!sc0 && p_sc) chk("high_phase", high_n, CD);
      if (!bus0.busy) low_n = 0;
      if (bus0.busy) busy_n++;
      if (!bus0.busy && p_busy) begin
        chk("busy_len", busy_n, 16 * D * CD);
        chk("done_at_end", bus0.done, 1);
        busy_n = 0;
      end
      if (bus0.done) begin
        got_done++;
        chk("done_width", p_done, 0);
      end
      p_sc = sc0;
      p_busy = bus0.busy;
      p_done = bus0.done;
      p_dt = sd0;
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while ((bus0.busy || bus0.done) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", bus0.busy, 0);
  endtask

  task automatic send(
    input bit rm,
    input logic [31:0] d,
    input logic [63:0] r,
    input logic [7:0] p,
    input int poke,
    input bit fin_poke
  );
    logic [7:0] first;
    int t;
    wait_idle();
    bus0.raw_mode = rm;
    bus0.data = d;
    bus0.raw = r;
    bus0.dp = p;
    bus0.start = 1'b1;
    first = model(rm, d, r, p);
    exp_done++;
    @(negedge clk);
    bus0.start = 1'b0;
    chk("latency_busy", bus0.busy, 1);
    chk("first_bit", sd0, first[7]);
    bus0.raw_mode = ~rm;
    bus0.data = $urandom;
    bus0.raw = {$urandom, $urandom};
    bus0.dp = 8'($urandom);
    if (poke > 0) begin
      repeat (poke - 1) @(negedge clk);
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
    end
    t = 0;
    while (!bus0.done && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", bus0.done, 1);
    if (fin_poke) begin
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      repeat (3) begin
        chk("fin_ignore", bus0.busy, 0);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dummy;
    int t;
    bus0.start = 0; bus0.raw_mode = 0;
    bus0.data = '0; bus0.raw = '0; bus0.dp = '0;
    bus1.start = 0; bus1.raw_mode = 0;
    bus1.data = 32'h12345678;
    bus1.raw = '0; bus1.dp = '0;
    bus2.start = 0; bus2.raw_mode = 1;
    bus2.data = '0;
    bus2.raw = 64'hFEDCBA9876543210;
    bus2.dp = '0;
    @(negedge clk);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_segclk", sc0, 0);
    chk("rst_segdt", sd0, 0);
    chk("rst_segclr", cl0, 0);
    chk("rst_segen", en0, 0);
    #12;
    rst_n = 1'b1;
    rst_n_r = 1'b1;
    @(negedge clk);
    chk("rel_segclr", cl0, 1);
    chk("rel_segen", en0, 1);
    chk("rel_busy", bus0.busy, 0);

    send(0, 32'h76543210, 64'h0, 8'h00, 0, 0);
    send(0, 32'h0000000F, 64'h0, 8'h01, 0, 0);
    send(1, 32'h0, 64'h0123456789ABCDEF,
         8'hFF, 0, 0);
    send(0, 32'h89ABCDEF, 64'h0, 8'hA5, 100, 1);
    for (int k = 0; k < 6; k++) begin
      send(1'($urandom), $urandom,
           {$urandom, $urandom},
           8'($urandom), 0, k == 2);
    end

    wait_idle();
    bus0.raw_mode = 0;
    bus0.data = $urandom;
    bus0.dp = 8'($urandom);
    bus0.start = 1'b1;
    dummy = model(0, bus0.data, 64'h0, bus0.dp);
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (49) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", bus0.busy, 0);
    chk("arst_done", bus0.done, 0);
    chk("arst_segclk", sc0, 0);
    chk("arst_segdt", sd0, 0);
    chk("arst_segclr", cl0, 0);
    chk("arst_segen", en0, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel2_segclr", cl0, 1);
    chk("rel2_segen", en0, 1);
    chk("rel2_done", bus0.done, 0);
    send(0, 32'hFEDCBA98, 64'h0, 8'h3C, 0, 0);
    wait_idle();

    t = 0;
    while ((st1.size() < 4 || st2.size() < 3) &&
           t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("ref1_frames", st1.size() >= 4, 1);
    chk("ref2_frames", st2.size() >= 3, 1);
    if (st1.size() > 0) chk("ref1_first", st1[0], 300);
    if (st2.size() > 0) chk("ref2_first", st2[0], 200);
    for (int i = 1; i < st1.size(); i++)
      chk("ref1_period", st1[i] - st1[i-1], 300);
    for (int i = 1; i < st2.size(); i++)
      chk("ref2_period", st2[i] - st2[i-1], 400);

    chk("queue_empty", exp_q.size(), 0);
    chk("done_count", got_done, exp_done);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
